// File: rtl/titan_lsu_ctrl.sv
// Load/store sequencer: issues one Wishbone cycle per MEM-stage access, stalls until done,
// aligns store data / byte selects and extends load data.
module titan_lsu_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic        lsu_mread_i,
  input  logic        lsu_mwrite_i,
  input  logic        lsu_mword_i,
  input  logic        lsu_mhw_i,
  input  logic        lsu_mbyte_i,
  input  logic        lsu_munsigned_i,
  input  logic        lsu_kill_i,
  output logic [31:0] lsu_data_o,
  output logic        lsu_err_o,
  output logic        lsu_stall_o,
  output logic [31:0] dwbm_addr_o,
  output logic [31:0] dwbm_dat_o,
  output logic [3:0]  dwbm_sel_o,
  output logic        dwbm_cyc_o,
  output logic        dwbm_stb_o,
  output logic        dwbm_we_o,
  input  logic [31:0] dwbm_dat_i,
  input  logic        dwbm_ack_i,
  input  logic        dwbm_err_i
);

  localparam int unsigned TimerW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {StIdle, StBus, StDone} state_e;
  typedef enum logic [1:0] {SzByte, SzHalf, SzWord} size_e;

  state_e            state_q;
  size_e             size_q;
  logic [TimerW-1:0] timer_q;
  logic              kill_q;
  logic              uns_q;
  logic [1:0]        lane_q;
  logic              err_q;
  logic [31:0]       data_q;

  logic        req;
  logic        timeout_hit;
  size_e       size_in;
  logic [3:0]  sel_in;
  logic [31:0] wdat_in;
  logic [31:0] load_ext;
  logic [15:0] half;
  logic [7:0]  byte_lane;

  assign req         = (lsu_mread_i | lsu_mwrite_i) & ~lsu_kill_i;
  assign timeout_hit = (timer_q == TimerW'(TIMEOUT - 1));

  always_comb begin
    size_in = SzByte;
    sel_in  = 4'b0001 << lsu_addr_i[1:0];
    wdat_in = {4{lsu_wdata_i[7:0]}};
    if (lsu_mword_i) begin
      size_in = SzWord;
      sel_in  = 4'b1111;
      wdat_in = lsu_wdata_i;
    end else if (lsu_mhw_i) begin
      size_in = SzHalf;
      sel_in  = lsu_addr_i[1] ? 4'b1100 : 4'b0011;
      wdat_in = {2{lsu_wdata_i[15:0]}};
    end
  end

  always_comb begin
    half = lane_q[1] ? dwbm_dat_i[31:16] : dwbm_dat_i[15:0];
    case (lane_q)
      2'd0:    byte_lane = dwbm_dat_i[7:0];
      2'd1:    byte_lane = dwbm_dat_i[15:8];
      2'd2:    byte_lane = dwbm_dat_i[23:16];
      default: byte_lane = dwbm_dat_i[31:24];
    endcase
    case (size_q)
      SzWord:  load_ext = dwbm_dat_i;
      SzHalf:  load_ext = {{16{half[15] & ~uns_q}}, half};
      default: load_ext = {{24{byte_lane[7] & ~uns_q}}, byte_lane};
    endcase
  end

  assign lsu_stall_o = (state_q == StIdle) ? req : (state_q == StBus);
  assign lsu_err_o   = err_q;
  assign lsu_data_o  = data_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      size_q      <= SzByte;
      timer_q     <= '0;
      kill_q      <= 1'b0;
      uns_q       <= 1'b0;
      lane_q      <= 2'b00;
      err_q       <= 1'b0;
      data_q      <= '0;
      dwbm_addr_o <= '0;
      dwbm_dat_o  <= '0;
      dwbm_sel_o  <= '0;
      dwbm_cyc_o  <= 1'b0;
      dwbm_stb_o  <= 1'b0;
      dwbm_we_o   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req) begin
            dwbm_addr_o <= {lsu_addr_i[31:2], 2'b00};
            dwbm_we_o   <= lsu_mwrite_i;
            dwbm_cyc_o  <= 1'b1;
            dwbm_stb_o  <= 1'b1;
            dwbm_sel_o  <= sel_in;
            dwbm_dat_o  <= wdat_in;
            size_q      <= size_in;
            uns_q       <= lsu_munsigned_i;
            lane_q      <= lsu_addr_i[1:0];
            timer_q     <= '0;
            kill_q      <= 1'b0;
            state_q     <= StBus;
          end
        end
        StBus: begin
          timer_q <= timer_q + TimerW'(1);
          if (lsu_kill_i) kill_q <= 1'b1;
          // A killed access still runs to completion on the bus; only its fault is hidden.
          if (dwbm_err_i || timeout_hit) begin
            err_q      <= ~kill_q;
            dwbm_cyc_o <= 1'b0;
            dwbm_stb_o <= 1'b0;
            dwbm_we_o  <= 1'b0;
            state_q    <= StDone;
          end else if (dwbm_ack_i) begin
            if (!dwbm_we_o) data_q <= load_ext;
            err_q      <= 1'b0;
            dwbm_cyc_o <= 1'b0;
            dwbm_stb_o <= 1'b0;
            dwbm_we_o  <= 1'b0;
            state_q    <= StDone;
          end
        end
        default: begin
          err_q   <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_titan_lsu_ctrl.sv
// Directed bench for titan_lsu_ctrl: scoreboard of expected load data / fault per access,
// checked with immediate assertions when the access reaches DONE.
module tb_titan_lsu_ctrl;

  localparam int unsigned TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] lsu_addr_i, lsu_wdata_i;
  logic        lsu_mread_i, lsu_mwrite_i, lsu_mword_i, lsu_mhw_i, lsu_mbyte_i;
  logic        lsu_munsigned_i, lsu_kill_i;
  logic [31:0] lsu_data_o;
  logic        lsu_err_o, lsu_stall_o;
  logic [31:0] dwbm_addr_o, dwbm_dat_o, dwbm_dat_i;
  logic [3:0]  dwbm_sel_o;
  logic        dwbm_cyc_o, dwbm_stb_o, dwbm_we_o, dwbm_ack_i, dwbm_err_i;

  titan_lsu_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .lsu_addr_i     (lsu_addr_i),
    .lsu_wdata_i    (lsu_wdata_i),
    .lsu_mread_i    (lsu_mread_i),
    .lsu_mwrite_i   (lsu_mwrite_i),
    .lsu_mword_i    (lsu_mword_i),
    .lsu_mhw_i      (lsu_mhw_i),
    .lsu_mbyte_i    (lsu_mbyte_i),
    .lsu_munsigned_i(lsu_munsigned_i),
    .lsu_kill_i     (lsu_kill_i),
    .lsu_data_o     (lsu_data_o),
    .lsu_err_o      (lsu_err_o),
    .lsu_stall_o    (lsu_stall_o),
    .dwbm_addr_o    (dwbm_addr_o),
    .dwbm_dat_o     (dwbm_dat_o),
    .dwbm_sel_o     (dwbm_sel_o),
    .dwbm_cyc_o     (dwbm_cyc_o),
    .dwbm_stb_o     (dwbm_stb_o),
    .dwbm_we_o      (dwbm_we_o),
    .dwbm_dat_i     (dwbm_dat_i),
    .dwbm_ack_i     (dwbm_ack_i),
    .dwbm_err_i     (dwbm_err_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_req();
    lsu_mread_i     = 1'b0;
    lsu_mwrite_i    = 1'b0;
    lsu_mword_i     = 1'b0;
    lsu_mhw_i       = 1'b0;
    lsu_mbyte_i     = 1'b0;
    lsu_munsigned_i = 1'b0;
  endtask

  // resp_at: BUS cycle (1-based) in which ack/err is driven; 0 = never. kill_at likewise.
  task automatic access(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic rd, input logic wr, input logic [2:0] whb,
                        input logic uns, input int resp_at, input logic r_ack,
                        input logic r_err, input logic [31:0] bus_dat, input int kill_at,
                        input logic [3:0] exp_sel, input logic [31:0] exp_dat,
                        input logic [31:0] exp_data, input logic exp_err, input int exp_bus);
    exp_t e;
    int   nbus;
    logic done;
    @(negedge clk);
    lsu_addr_i      = addr;
    lsu_wdata_i     = wdata;
    lsu_mread_i     = rd;
    lsu_mwrite_i    = wr;
    {lsu_mword_i, lsu_mhw_i, lsu_mbyte_i} = whb;
    lsu_munsigned_i = uns;
    e.data = exp_data;
    e.err  = exp_err;
    sb_q.push_back(e);
    #1;
    chk({tag, "_idle_stall"}, 32'(lsu_stall_o), 32'd1);
    chk({tag, "_idle_cyc"}, 32'(dwbm_cyc_o), 32'd0);
    @(negedge clk);
    clear_req();
    lsu_addr_i  = 32'hFFFF_FFFF;
    lsu_wdata_i = 32'h0;
    chk({tag, "_cyc"}, 32'(dwbm_cyc_o), 32'd1);
    chk({tag, "_stb"}, 32'(dwbm_stb_o), 32'd1);
    chk({tag, "_we"}, 32'(dwbm_we_o), 32'(wr));
    chk({tag, "_addr"}, dwbm_addr_o, {addr[31:2], 2'b00});
    chk({tag, "_sel"}, 32'(dwbm_sel_o), 32'(exp_sel));
    if (wr) chk({tag, "_wdat"}, dwbm_dat_o, exp_dat);
    nbus = 0;
    done = 1'b0;
    for (int k = 1; k <= int'(TIMEOUT) + 4 && !done; k++) begin
      nbus++;
      if (k == kill_at) lsu_kill_i = 1'b1;
      if (k == resp_at) begin
        dwbm_ack_i = r_ack;
        dwbm_err_i = r_err;
        dwbm_dat_i = bus_dat;
      end
      @(negedge clk);
      dwbm_ack_i = 1'b0;
      dwbm_err_i = 1'b0;
      dwbm_dat_i = 32'h5555_5555;
      if (!lsu_stall_o) done = 1'b1;
    end
    chk({tag, "_bus_cycles"}, 32'(nbus), 32'(exp_bus));
    e = sb_q.pop_front();
    chk({tag, "_done_err"}, 32'(lsu_err_o), 32'(e.err));
    chk({tag, "_done_data"}, lsu_data_o, e.data);
    chk({tag, "_done_cyc"}, 32'(dwbm_cyc_o | dwbm_stb_o), 32'd0);
    lsu_kill_i = 1'b0;
    @(negedge clk);
    chk({tag, "_after_err"}, 32'(lsu_err_o), 32'd0);
    chk({tag, "_after_data"}, lsu_data_o, e.data);
  endtask

  initial begin
    rst_i       = 1'b1;
    lsu_addr_i  = '0;
    lsu_wdata_i = '0;
    lsu_kill_i  = 1'b0;
    dwbm_dat_i  = '0;
    dwbm_ack_i  = 1'b0;
    dwbm_err_i  = 1'b0;
    clear_req();
    repeat (2) @(negedge clk);
    chk("rst_cyc", 32'(dwbm_cyc_o), 32'd0);
    chk("rst_stb", 32'(dwbm_stb_o), 32'd0);
    chk("rst_stall", 32'(lsu_stall_o), 32'd0);
    chk("rst_err", 32'(lsu_err_o), 32'd0);
    chk("rst_data", lsu_data_o, 32'd0);
    chk("rst_sel", 32'(dwbm_sel_o), 32'd0);
    rst_i = 1'b0;

    // tag, addr, wdata, rd, wr, {w,h,b}, uns, resp_at, ack, err, bus_dat, kill_at,
    // sel, wdat, data, err, bus cycles
    access("lw", 32'h1004, 0, 1, 0, 3'b100, 0, 2, 1, 0, 32'hDEADBEEF, 0,
           4'b1111, 0, 32'hDEADBEEF, 0, 2);
    access("lb", 32'h2003, 0, 1, 0, 3'b001, 0, 1, 1, 0, 32'h80112233, 0,
           4'b1000, 0, 32'hFFFFFF80, 0, 1);
    access("lbu", 32'h2003, 0, 1, 0, 3'b001, 1, 1, 1, 0, 32'h80112233, 0,
           4'b1000, 0, 32'h00000080, 0, 1);
    access("lhu", 32'h2002, 0, 1, 0, 3'b010, 1, 1, 1, 0, 32'h80112233, 0,
           4'b1100, 0, 32'h00008011, 0, 1);
    access("lh_hi", 32'h2002, 0, 1, 0, 3'b010, 0, 1, 1, 0, 32'h80112233, 0,
           4'b1100, 0, 32'hFFFF8011, 0, 1);
    access("lh_lo", 32'h2000, 0, 1, 0, 3'b010, 0, 1, 1, 0, 32'h80112233, 0,
           4'b0011, 0, 32'h00002233, 0, 1);
    access("lb1", 32'h2001, 0, 1, 0, 3'b001, 0, 1, 1, 0, 32'h80112233, 0,
           4'b0010, 0, 32'h00000022, 0, 1);
    access("sb", 32'h3001, 32'h000000A5, 0, 1, 3'b001, 0, 1, 1, 0, 32'h0, 0,
           4'b0010, 32'hA5A5A5A5, 32'h00000022, 0, 1);
    access("sh", 32'h3002, 32'h00001234, 0, 1, 3'b010, 0, 2, 1, 0, 32'h0, 0,
           4'b1100, 32'h12341234, 32'h00000022, 0, 2);
    access("sw_rdwr", 32'h3004, 32'hCAFEF00D, 1, 1, 3'b111, 0, 1, 1, 0, 32'h77777777, 0,
           4'b1111, 32'hCAFEF00D, 32'h00000022, 0, 1);
    access("lw_err", 32'h4000, 0, 1, 0, 3'b100, 0, 1, 0, 1, 32'h12345678, 0,
           4'b1111, 0, 32'h00000022, 1, 1);
    access("lw_ackerr", 32'h4000, 0, 1, 0, 3'b100, 0, 1, 1, 1, 32'h12345678, 0,
           4'b1111, 0, 32'h00000022, 1, 1);
    access("lw_tmo", 32'h4008, 0, 1, 0, 3'b100, 0, 0, 0, 0, 32'h0, 0,
           4'b1111, 0, 32'h00000022, 1, int'(TIMEOUT));
    access("lw_killbus", 32'h400C, 0, 1, 0, 3'b100, 0, 2, 0, 1, 32'h0, 1,
           4'b1111, 0, 32'h00000022, 0, 2);

    // Killed request in IDLE: no stall, no bus cycle.
    @(negedge clk);
    lsu_addr_i  = 32'h5000;
    lsu_mread_i = 1'b1;
    lsu_mword_i = 1'b1;
    lsu_kill_i  = 1'b1;
    #1;
    chk("kill_idle_stall", 32'(lsu_stall_o), 32'd0);
    @(negedge clk);
    chk("kill_idle_cyc", 32'(dwbm_cyc_o), 32'd0);
    chk("kill_idle_stall2", 32'(lsu_stall_o), 32'd0);
    clear_req();
    lsu_kill_i = 1'b0;

    // Reset while a cycle is outstanding drops cyc/stb at the reset edge.
    @(negedge clk);
    lsu_addr_i  = 32'h6000;
    lsu_mread_i = 1'b1;
    lsu_mword_i = 1'b1;
    @(negedge clk);
    clear_req();
    chk("rstbus_cyc_before", 32'(dwbm_cyc_o), 32'd1);
    rst_i = 1'b1;
    @(negedge clk);
    chk("rstbus_cyc", 32'(dwbm_cyc_o), 32'd0);
    chk("rstbus_stb", 32'(dwbm_stb_o), 32'd0);
    chk("rstbus_stall", 32'(lsu_stall_o), 32'd0);
    chk("rstbus_data", lsu_data_o, 32'd0);
    rst_i = 1'b0;
    access("lw_post_rst", 32'h0010, 0, 1, 0, 3'b100, 0, 1, 1, 0, 32'h13572468, 0,
           4'b1111, 0, 32'h13572468, 0, 1);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
